pm_min_select_pipe: RTL and testbench
=====================================

Name: pm_min_select_pipe

Overview:
- Pipelined, streaming best-path-metric selector for the Viterbi ACS/traceback boundary.
- Accepts a frame of NUM_PM path metrics as BEATS = NUM_PM/LANES beats of LANES metrics each.
- Reduces each beat through a registered comparator tree, then keeps a running best across the beats of the frame.
- Emits the winning metric and its remapped state index once per frame. Traceback uses this index as its start state.

Parameters:
- NUM_PM, 64: path metrics per frame; power of two, ≥ LANES.
- LANES, 16: metrics per beat; power of two, ≥ 2. Tree depth D = log2(LANES).
- PM_W, 8: path-metric width, modulo-normalised.
- OUT_IDX_W, 7: output index width; ≥ log2(NUM_PM).
- SEL_MAX, 0: 0 selects the minimum metric, 1 selects the maximum.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  beat valid; no backpressure, so the source may insert bubbles
- in_pm  in  LANES*PM_W  lane j occupies bits [j*PM_W +: PM_W]
- idx_base  in  OUT_IDX_W  index offset; sampled on the first valid beat of a frame
- idx_reverse  in  1  index mirror mode; sampled on the first valid beat of a frame
- out_valid  out  1  one-cycle pulse marking a frame result
- out_pm  out  PM_W  winning metric
- out_idx  out  OUT_IDX_W  remapped index of the winner
- busy  out  1  high while a frame is partially accepted or in flight

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, out_pm=0, out_idx=0, busy=0.
  - Beat counter=0; all pipeline valid bits=0; accumulator cleared.
  - Reset mid-frame discards the partial frame and all in-flight beats; no out_valid is produced for them.
- Comparison rule, for a at the lower raw index and b at the higher raw index:
  - d = (a - b) mod 2^PM_W.
  - SEL_MAX=0: a wins iff d[PM_W-1]=1 or a==b.
  - SEL_MAX=1: a wins iff d[PM_W-1]=0.
  - Equal metrics therefore always resolve to the lower raw index, in the tree and across beats.
  - Correctness requires the metric spread to be < 2^(PM_W-1); this is not checked.
- Raw index = beat*LANES + lane, width log2(NUM_PM).
- Tree:
  - D levels, each level registered; a valid bit travels with each level.
  - A bubble (in_valid=0) propagates as invalid and never touches the accumulator.
- Beat counter:
  - Increments on each valid input beat and wraps from BEATS-1 to 0.
  - Beat number and frame-first/last tags travel with the beat through the tree.
- Accumulator stage, acting on a valid tree output:
  - Tagged first: load unconditionally.
  - Otherwise: replace only if the new candidate wins, with the accumulator treated as lower-index operand a.
- Output:
  - When the tree output tagged last is accumulated, the cycle after that update drives out_valid=1 for one cycle with final out_pm/out_idx.
  - Latency from the clk edge accepting the last beat to out_valid high is D+1 cycles (5 at defaults).
  - out_pm/out_idx hold their value until the next frame's result.
- Index remap, taken modulo 2^OUT_IDX_W:
  - idx_reverse=0: out_idx = idx_base + raw.
  - idx_reverse=1: out_idx = idx_base + (NUM_PM-1-raw).
  - Base and mode are captured at frame start and travel with the frame; changes mid-frame have no effect.
- Back-to-back frames at full rate are supported with no idle cycle. Consecutive frames may overlap in the tree; their results stay distinct and in order.
- busy is high from the first valid beat until the out_valid cycle of the last accepted frame.

Test Plan:
- Equal metrics: all 64 metrics = 5, base=0, reverse=0 -> out_pm=5, out_idx=0. Same frame with reverse=1 -> out_idx=63.
- Unique minimum: 4 contiguous beats, raw 39 = 3, rest 100, base=0, reverse=0 -> out_pm=3, out_idx=39; out_valid exactly 5 cycles after the last-beat edge, one cycle wide.
- Wrap-around: raw 10 = 250, raw 20 = 4, rest = 10 -> out_pm=250, out_idx=10 (modulo win). The same frame with SEL_MAX=1 build -> out_pm=10, out_idx=0.
- Bubbles: frame 2 beats separated by 3 idle cycles each -> same result as contiguous; out_valid 5 cycles after the last valid beat.
- Reset mid-frame: 2 beats, rst_n=0 for 1 cycle, then a full frame with minimum 7 at raw 50 -> exactly one out_valid, out_pm=7, out_idx=50. busy=0 the cycle after reset.
- Back-to-back: frame A (min at raw 0, base=64, reverse=1) immediately followed by frame B (min at raw 63, base=0, reverse=0) -> pulses on consecutive-frame cycles 4 apart, out_idx=127 then 63.

Source files
------------

// File: rtl/pm_min_select_if.sv
// Handshake/bus bundle for the best-path-metric selector: beat stream in,
// one winning metric/index per frame out.
interface pm_min_select_if #(
  parameter int LANES     = 16,
  parameter int PM_W      = 8,
  parameter int OUT_IDX_W = 7
);
  logic                  in_valid;
  logic [LANES*PM_W-1:0] in_pm;
  logic [OUT_IDX_W-1:0]  idx_base;
  logic                  idx_reverse;
  logic                  out_valid;
  logic [PM_W-1:0]       out_pm;
  logic [OUT_IDX_W-1:0]  out_idx;
  logic                  busy;

  modport master (
    output in_valid, in_pm, idx_base, idx_reverse,
    input  out_valid, out_pm, out_idx, busy
  );

  modport slave (
    input  in_valid, in_pm, idx_base, idx_reverse,
    output out_valid, out_pm, out_idx, busy
  );
endinterface

// File: rtl/pm_min_select_pipe.sv
// Streaming best-path-metric selector: registered comparator tree per beat,
// running best across a frame's beats, remapped winner index per frame.

// Modulo-aware pairwise select; operand a is always the lower raw index.
module pm_cmp_node #(
  parameter int PM_W    = 8,
  parameter int IDX_W   = 4,
  parameter int SEL_MAX = 0
) (
  input  logic [PM_W-1:0]  a_pm,
  input  logic [IDX_W-1:0] a_idx,
  input  logic [PM_W-1:0]  b_pm,
  input  logic [IDX_W-1:0] b_idx,
  output logic [PM_W-1:0]  w_pm,
  output logic [IDX_W-1:0] w_idx
);
  logic [PM_W-1:0] diff;
  logic            a_wins;

  always_comb begin
    diff = a_pm - b_pm;
    if (SEL_MAX != 0) a_wins = ~diff[PM_W-1];
    else              a_wins = diff[PM_W-1] | (a_pm == b_pm);
    w_pm  = a_wins ? a_pm  : b_pm;
    w_idx = a_wins ? a_idx : b_idx;
  end
endmodule

module pm_min_select_pipe #(
  parameter int NUM_PM    = 64,
  parameter int LANES     = 16,
  parameter int PM_W      = 8,
  parameter int OUT_IDX_W = 7,
  parameter int SEL_MAX   = 0
) (
  input logic           clk,
  input logic           rst_n,
  pm_min_select_if.slave bus
);
  localparam int D      = $clog2(LANES);
  localparam int LW     = D;
  localparam int BEATS  = NUM_PM / LANES;
  localparam int RAW_W  = $clog2(NUM_PM);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef struct packed {
    logic [BEAT_W-1:0]    beat;
    logic                 first;
    logic                 last;
    logic [OUT_IDX_W-1:0] base;
    logic                 rev;
  } tag_t;

  // ---------------- comparator tree ----------------
  // Heap layout: node i compares children 2i (lower lanes) and 2i+1.
  // Children at or above LANES are the raw input lanes.
  logic [LANES-1:0][PM_W-1:0] leaf_pm;
  logic [LANES-1:0][LW-1:0]   leaf_idx;
  logic [LANES-1:1][PM_W-1:0] nd_pm_d,  nd_pm_q;
  logic [LANES-1:1][LW-1:0]   nd_idx_d, nd_idx_q;

  genvar j, i;
  for (j = 0; j < LANES; j++) begin : g_leaf
    assign leaf_pm[j]  = bus.in_pm[j*PM_W +: PM_W];
    assign leaf_idx[j] = LW'(j);
  end

  for (i = 1; i < LANES; i++) begin : g_node
    logic [PM_W-1:0] l_pm,  r_pm;
    logic [LW-1:0]   l_idx, r_idx;

    if (2*i >= LANES) begin : g_from_leaf
      assign l_pm  = leaf_pm[2*i-LANES];
      assign l_idx = leaf_idx[2*i-LANES];
      assign r_pm  = leaf_pm[2*i+1-LANES];
      assign r_idx = leaf_idx[2*i+1-LANES];
    end else begin : g_from_node
      assign l_pm  = nd_pm_q[2*i];
      assign l_idx = nd_idx_q[2*i];
      assign r_pm  = nd_pm_q[2*i+1];
      assign r_idx = nd_idx_q[2*i+1];
    end

    pm_cmp_node #(.PM_W(PM_W), .IDX_W(LW), .SEL_MAX(SEL_MAX)) u_cmp (
      .a_pm (l_pm),
      .a_idx(l_idx),
      .b_pm (r_pm),
      .b_idx(r_idx),
      .w_pm (nd_pm_d[i]),
      .w_idx(nd_idx_d[i])
    );
  end

  // Tree data is qualified by vld_pipe_q, so it needs no reset.
  always_ff @(posedge clk) begin
    nd_pm_q  <= nd_pm_d;
    nd_idx_q <= nd_idx_d;
  end

  // ---------------- beat counter and tag pipeline ----------------
  logic [BEAT_W-1:0] beat_cnt_d, beat_cnt_q;
  logic              last_beat;
  logic [D:1]        vld_pipe_d, vld_pipe_q;
  tag_t [D:1]        tag_d, tag_q;

  assign last_beat = (beat_cnt_q == BEAT_W'(BEATS-1));

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (bus.in_valid) beat_cnt_d = last_beat ? '0 : beat_cnt_q + BEAT_W'(1);

    vld_pipe_d = '0;
    tag_d      = '0;
    vld_pipe_d[1]  = bus.in_valid;
    tag_d[1].beat  = beat_cnt_q;
    tag_d[1].first = (beat_cnt_q == '0);
    tag_d[1].last  = last_beat;
    tag_d[1].base  = bus.idx_base;
    tag_d[1].rev   = bus.idx_reverse;
    for (int k = 2; k <= D; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      tag_d[k]      = tag_q[k-1];
    end
  end

  // ---------------- cross-beat accumulator ----------------
  tag_t                 tag_o;
  logic [RAW_W-1:0]     cand_raw;
  logic [PM_W-1:0]      acc_win_pm;
  logic [RAW_W-1:0]     acc_win_raw;
  logic [PM_W-1:0]      acc_pm_d,   acc_pm_q;
  logic [RAW_W-1:0]     acc_raw_d,  acc_raw_q;
  logic [OUT_IDX_W-1:0] acc_base_d, acc_base_q;
  logic                 acc_rev_d,  acc_rev_q;
  logic                 done_d,     done_q;

  assign tag_o    = tag_q[D];
  assign cand_raw = (RAW_W'(tag_o.beat) << LW) | RAW_W'(nd_idx_q[1]);

  // The held best is always from an earlier beat, hence the a operand.
  pm_cmp_node #(.PM_W(PM_W), .IDX_W(RAW_W), .SEL_MAX(SEL_MAX)) u_acc_cmp (
    .a_pm (acc_pm_q),
    .a_idx(acc_raw_q),
    .b_pm (nd_pm_q[1]),
    .b_idx(cand_raw),
    .w_pm (acc_win_pm),
    .w_idx(acc_win_raw)
  );

  always_comb begin
    acc_pm_d   = acc_pm_q;
    acc_raw_d  = acc_raw_q;
    acc_base_d = acc_base_q;
    acc_rev_d  = acc_rev_q;
    if (vld_pipe_q[D]) begin
      if (tag_o.first) begin
        acc_pm_d   = nd_pm_q[1];
        acc_raw_d  = cand_raw;
        acc_base_d = tag_o.base;
        acc_rev_d  = tag_o.rev;
      end else begin
        acc_pm_d  = acc_win_pm;
        acc_raw_d = acc_win_raw;
      end
    end
    done_d = vld_pipe_q[D] & tag_o.last;
  end

  // ---------------- output stage ----------------
  logic [RAW_W-1:0]     raw_eff;
  logic                 out_valid_d, out_valid_q;
  logic [PM_W-1:0]      out_pm_d,    out_pm_q;
  logic [OUT_IDX_W-1:0] out_idx_d,   out_idx_q;
  logic                 busy_d,      busy_q;

  always_comb begin
    // NUM_PM is a power of two, so NUM_PM-1-raw is the bitwise complement.
    raw_eff     = acc_rev_q ? ~acc_raw_q : acc_raw_q;
    out_valid_d = done_q;
    out_pm_d    = out_pm_q;
    out_idx_d   = out_idx_q;
    if (done_q) begin
      out_pm_d  = acc_pm_q;
      out_idx_d = acc_base_q + OUT_IDX_W'(raw_eff);
    end
    busy_d = bus.in_valid | (beat_cnt_q != '0) | (|vld_pipe_q) | done_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_q  <= '0;
      vld_pipe_q  <= '0;
      tag_q       <= '0;
      acc_pm_q    <= '0;
      acc_raw_q   <= '0;
      acc_base_q  <= '0;
      acc_rev_q   <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_pm_q    <= '0;
      out_idx_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      vld_pipe_q  <= vld_pipe_d;
      tag_q       <= tag_d;
      acc_pm_q    <= acc_pm_d;
      acc_raw_q   <= acc_raw_d;
      acc_base_q  <= acc_base_d;
      acc_rev_q   <= acc_rev_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_pm_q    <= out_pm_d;
      out_idx_q   <= out_idx_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_pm    = out_pm_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_pm_min_select_pipe.sv
// Bench for pm_min_select_pipe: a min build and a max build share one stimulus
// stream; results are checked against a sequential-scan reference model.
module tb_pm_min_select_pipe;
  localparam int NUM_PM    = 64;
  localparam int LANES     = 16;
  localparam int PM_W      = 8;
  localparam int OUT_IDX_W = 7;
  localparam int BEATS     = NUM_PM / LANES;
  localparam int LAT       = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pm_min_select_if #(.LANES(LANES), .PM_W(PM_W), .OUT_IDX_W(OUT_IDX_W)) bus_min ();
  pm_min_select_if #(.LANES(LANES), .PM_W(PM_W), .OUT_IDX_W(OUT_IDX_W)) bus_max ();

  assign bus_max.in_valid    = bus_min.in_valid;
  assign bus_max.in_pm       = bus_min.in_pm;
  assign bus_max.idx_base    = bus_min.idx_base;
  assign bus_max.idx_reverse = bus_min.idx_reverse;

  pm_min_select_pipe #(.NUM_PM(NUM_PM), .LANES(LANES), .PM_W(PM_W),
                       .OUT_IDX_W(OUT_IDX_W), .SEL_MAX(0)) u_min (
    .clk(clk), .rst_n(rst_n), .bus(bus_min));
  pm_min_select_pipe #(.NUM_PM(NUM_PM), .LANES(LANES), .PM_W(PM_W),
                       .OUT_IDX_W(OUT_IDX_W), .SEL_MAX(1)) u_max (
    .clk(clk), .rst_n(rst_n), .bus(bus_max));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int pm; int idx; int cyc; } res_t;
  res_t q_min[$];
  res_t q_max[$];

  always @(negedge clk) begin
    res_t r;
    if (bus_min.out_valid === 1'b1) begin
      r.pm = int'(bus_min.out_pm); r.idx = int'(bus_min.out_idx); r.cyc = cyc;
      q_min.push_back(r);
    end
    if (bus_max.out_valid === 1'b1) begin
      r.pm = int'(bus_max.out_pm); r.idx = int'(bus_max.out_idx); r.cyc = cyc;
      q_max.push_back(r);
    end
  end

  logic [PM_W-1:0] fpm [NUM_PM];
  int last_edge;
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Winner by linear scan over raw indices; a later index replaces the best
  // only if it is strictly better in the modulo (signed-distance) sense.
  function automatic int model_raw(input bit sel_max);
    int best;
    int sd;
    logic [PM_W-1:0] diff;
    best = 0;
    for (int r = 1; r < NUM_PM; r++) begin
      diff = fpm[r] - fpm[best];
      sd = int'($signed(diff));
      if (sel_max ? (sd > 0) : (sd < 0)) best = r;
    end
    return best;
  endfunction

  function automatic int remap(input int base, input int rev, input int raw);
    return (base + ((rev != 0) ? (NUM_PM - 1 - raw) : raw)) % (1 << OUT_IDX_W);
  endfunction

  // Base/mode are only meaningful on the first beat; later beats get noise.
  task automatic send_beats(input int base, input int rev, input int gap, input int nb);
    for (int b = 0; b < nb; b++) begin
      bus_min.in_valid = 1'b1;
      for (int j = 0; j < LANES; j++) bus_min.in_pm[j*PM_W +: PM_W] = fpm[b*LANES+j];
      bus_min.idx_base    = (b == 0) ? OUT_IDX_W'(base) : OUT_IDX_W'($urandom);
      bus_min.idx_reverse = (b == 0) ? rev[0] : 1'($urandom);
      @(posedge clk); #1;
      bus_min.in_valid = 1'b0;
      if (b == nb - 1) last_edge = cyc;
      else repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic build(input int fill, input int r1, input int v1, input int r2, input int v2);
    for (int r = 0; r < NUM_PM; r++) fpm[r] = PM_W'(fill);
    if (r1 >= 0) fpm[r1] = PM_W'(v1);
    if (r2 >= 0) fpm[r2] = PM_W'(v2);
  endtask

  task automatic wait_results(input int n);
    for (int t = 0; t < 300 && (q_min.size() < n || q_max.size() < n); t++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    int fill; int r1; int v1; int r2; int v2;
    int base; int rev; int gap;
    int mn_pm; int mn_idx; int mx_pm; int mx_idx;
  } vec_t;
  vec_t vt[7];

  typedef struct { int mn_pm; int mn_idx; int mx_pm; int mx_idx; } exp_t;
  exp_t exp_q[$];

  initial begin
    vt[0] = '{fill: 5,   r1: -1, v1: 0,   r2: -1, v2: 0, base: 0,   rev: 0, gap: 0,
              mn_pm: 5,   mn_idx: 0,  mx_pm: 5,   mx_idx: 0};
    vt[1] = '{fill: 5,   r1: -1, v1: 0,   r2: -1, v2: 0, base: 0,   rev: 1, gap: 0,
              mn_pm: 5,   mn_idx: 63, mx_pm: 5,   mx_idx: 63};
    vt[2] = '{fill: 100, r1: 39, v1: 3,   r2: -1, v2: 0, base: 0,   rev: 0, gap: 0,
              mn_pm: 3,   mn_idx: 39, mx_pm: 100, mx_idx: 0};
    vt[3] = '{fill: 10,  r1: 10, v1: 250, r2: 20, v2: 4, base: 0,   rev: 0, gap: 0,
              mn_pm: 250, mn_idx: 10, mx_pm: 10,  mx_idx: 0};
    vt[4] = '{fill: 100, r1: 39, v1: 3,   r2: -1, v2: 0, base: 0,   rev: 0, gap: 3,
              mn_pm: 3,   mn_idx: 39, mx_pm: 100, mx_idx: 0};
    vt[5] = '{fill: 100, r1: 5,  v1: 20,  r2: -1, v2: 0, base: 120, rev: 1, gap: 1,
              mn_pm: 20,  mn_idx: 50, mx_pm: 100, mx_idx: 55};
    vt[6] = '{fill: 100, r1: 17, v1: 3,   r2: 49, v2: 3, base: 0,   rev: 0, gap: 0,
              mn_pm: 3,   mn_idx: 17, mx_pm: 100, mx_idx: 0};

    bus_min.in_valid = 1'b0;
    bus_min.in_pm = '0;
    bus_min.idx_base = '0;
    bus_min.idx_reverse = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", int'(bus_min.out_valid), 0);
    check("reset out_pm", int'(bus_min.out_pm), 0);
    check("reset out_idx", int'(bus_min.out_idx), 0);
    check("reset busy", int'(bus_min.busy), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed frames from the table
    for (int t = 0; t < 7; t++) begin
      build(vt[t].fill, vt[t].r1, vt[t].v1, vt[t].r2, vt[t].v2);
      send_beats(vt[t].base, vt[t].rev, vt[t].gap, BEATS);
      wait_results(1);
      check($sformatf("vec%0d min count", t), q_min.size(), 1);
      check($sformatf("vec%0d max count", t), q_max.size(), 1);
      if (q_min.size() > 0) begin
        check($sformatf("vec%0d min pm", t), q_min[0].pm, vt[t].mn_pm);
        check($sformatf("vec%0d min idx", t), q_min[0].idx, vt[t].mn_idx);
        check($sformatf("vec%0d latency", t), q_min[0].cyc - last_edge, LAT);
      end
      if (q_max.size() > 0) begin
        check($sformatf("vec%0d max pm", t), q_max[0].pm, vt[t].mx_pm);
        check($sformatf("vec%0d max idx", t), q_max[0].idx, vt[t].mx_idx);
      end
      check($sformatf("vec%0d busy idle", t), int'(bus_min.busy), 0);
      q_min.delete();
      q_max.delete();
    end

    // Reset in the middle of a frame discards it
    for (int r = 0; r < NUM_PM; r++) fpm[r] = PM_W'($urandom_range(0, 100));
    send_beats(0, 0, 0, 2);
    check("busy mid-frame", int'(bus_min.busy), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("busy after reset", int'(bus_min.busy), 0);
    check("out_valid after reset", int'(bus_min.out_valid), 0);
    build(100, 50, 7, -1, 0);
    send_beats(0, 0, 0, BEATS);
    wait_results(1);
    check("rst min count", q_min.size(), 1);
    check("rst max count", q_max.size(), 1);
    if (q_min.size() > 0) begin
      check("rst min pm", q_min[0].pm, 7);
      check("rst min idx", q_min[0].idx, 50);
    end
    if (q_max.size() > 0) check("rst max idx", q_max[0].idx, 0);
    q_min.delete();
    q_max.delete();

    // Back-to-back frames, no idle cycle between them
    begin
      int last_a;
      build(100, 0, 1, -1, 0);
      send_beats(64, 1, 0, BEATS);
      last_a = last_edge;
      build(100, 63, 1, -1, 0);
      send_beats(0, 0, 0, BEATS);
      wait_results(2);
      check("b2b min count", q_min.size(), 2);
      check("b2b max count", q_max.size(), 2);
      if (q_min.size() >= 2) begin
        check("b2b A latency", q_min[0].cyc - last_a, LAT);
        check("b2b spacing", q_min[1].cyc - q_min[0].cyc, BEATS);
        check("b2b A pm", q_min[0].pm, 1);
        check("b2b A idx", q_min[0].idx, 127);
        check("b2b B pm", q_min[1].pm, 1);
        check("b2b B idx", q_min[1].idx, 63);
      end
      if (q_max.size() >= 2) begin
        check("b2b A max idx", q_max[0].idx, 126);
        check("b2b B max idx", q_max[1].idx, 0);
      end
      q_min.delete();
      q_max.delete();
    end

    // Randomized frames against the reference model
    for (int f = 0; f < 16; f++) begin
      exp_t e;
      int off, base, rev, mn, mx;
      off = $urandom_range(0, 255);
      for (int r = 0; r < NUM_PM; r++) fpm[r] = PM_W'(off + $urandom_range(0, 120));
      base = $urandom_range(0, 127);
      rev = $urandom_range(0, 1);
      mn = model_raw(1'b0);
      mx = model_raw(1'b1);
      e.mn_pm = int'(fpm[mn]); e.mn_idx = remap(base, rev, mn);
      e.mx_pm = int'(fpm[mx]); e.mx_idx = remap(base, rev, mx);
      exp_q.push_back(e);
      send_beats(base, rev, $urandom_range(0, 2), BEATS);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_results(16);
    check("rand min count", q_min.size(), 16);
    check("rand max count", q_max.size(), 16);
    for (int f = 0; f < 16; f++) begin
      if (f < q_min.size()) begin
        check($sformatf("rand%0d min pm", f), q_min[f].pm, exp_q[f].mn_pm);
        check($sformatf("rand%0d min idx", f), q_min[f].idx, exp_q[f].mn_idx);
      end
      if (f < q_max.size()) begin
        check($sformatf("rand%0d max pm", f), q_max[f].pm, exp_q[f].mx_pm);
        check($sformatf("rand%0d max idx", f), q_max[f].idx, exp_q[f].mx_idx);
      end
    end
    check("rand busy idle", int'(bus_min.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
